// File: rtl/approx_acc_pkg.sv
// rtl/approx_acc_pkg.sv - shared constants and FSM state encoding for the product accumulator
// Macro: APPROX_ACC_SAT_EN (used by approx_acc_add) selects saturating accumulation.
package approx_acc_pkg;

    localparam int DEF_ACC_W = 24;
    localparam int DEF_CNT_W = 8;
    localparam int PROD_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/approx_prod_accum_if.sv
// rtl/approx_prod_accum_if.sv - product beat input and result output handshake bundle
// Signals:
//   in_valid/in_ready/in_prod/in_last      : product beat stream into the accumulator
//   out_valid/out_ready/out_sum/out_cnt/out_ovf : dot-product result toward the consumer
// Modports: master = upstream/consumer side, slave = accumulator side.
interface approx_prod_accum_if
    import approx_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_cnt, out_ovf
    );
endinterface

// File: rtl/approx_acc_add.sv
// rtl/approx_acc_add.sv - ACC_W-bit accumulate adder with carry-out and optional saturation
// Ports:
//   i_acc   : current accumulator value
//   i_prod  : 16-bit unsigned product, zero-extended before the add
//   o_sum   : next accumulator value (wrapped, or clamped when APPROX_ACC_SAT_EN is defined)
//   o_carry : carry out of bit ACC_W-1 (overflow of this addition)
// Macro: APPROX_ACC_SAT_EN
module approx_acc_add
    import approx_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);
    logic [ACC_W:0] w_full;

    assign w_full  = {1'b0, i_acc} + (ACC_W+1)'(i_prod);
    assign o_carry = w_full[ACC_W];

`ifdef APPROX_ACC_SAT_EN
    // Once clamped at all-ones, any nonzero addend carries again and re-clamps,
    // so the value stays pinned for the rest of the dot product.
    assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    assign o_sum = w_full[ACC_W-1:0];
`endif
endmodule

// File: rtl/approx_prod_accum.sv
// rtl/approx_prod_accum.sv - accumulates approximate-multiplier products into a dot-product result
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : approx_prod_accum_if.slave (beat stream in, result out)
// Macro: APPROX_ACC_SAT_EN (saturate instead of wrap; forwarded to approx_acc_add)
module approx_prod_accum
    import approx_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    approx_prod_accum_if.slave bus
);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ACCUM = ST_ACCUM;
    localparam logic [1:0] S_HOLD  = ST_HOLD;

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;

    // Outputs are gated by rst so nothing is advertised while reset is held,
    // even in the first reset cycle before the state register clears.
    assign w_in_ready  = !rst && (r_state != S_HOLD);
    assign w_out_valid = !rst && (r_state == S_HOLD);
    assign w_accept    = bus.in_valid && w_in_ready;

    approx_acc_add #(.ACC_W(ACC_W)) u_add (
        .i_acc   (r_acc),
        .i_prod  (bus.in_prod),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc   <= ACC_W'(bus.in_prod);
                        r_cnt   <= CNT_W'(1);
                        r_ovf   <= 1'b0;
                        r_state <= bus.in_last ? S_HOLD : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_sum;
                        // Beat count sticks at all-ones; summing continues regardless.
                        r_cnt   <= (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
                        r_ovf   <= r_ovf | w_carry;
                        r_state <= bus.in_last ? S_HOLD : S_ACCUM;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_sum   = w_out_valid ? r_acc : '0;
    assign bus.out_cnt   = w_out_valid ? r_cnt : '0;
    assign bus.out_ovf   = w_out_valid ? r_ovf : 1'b0;
endmodule

// File: tb/tb_approx_prod_accum.sv
// tb/tb_approx_prod_accum.sv - self-checking bench for approx_prod_accum
module tb_approx_prod_accum;
    import approx_acc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    approx_prod_accum_if #(.ACC_W(24), .CNT_W(8)) m_if ();
    approx_prod_accum_if #(.ACC_W(17), .CNT_W(8)) a_if ();
    approx_prod_accum_if #(.ACC_W(24), .CNT_W(2)) c_if ();

    approx_prod_accum #(.ACC_W(24), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(m_if.slave));
    approx_prod_accum #(.ACC_W(17), .CNT_W(8)) dut_a17 (.clk(clk), .rst(rst), .bus(a_if.slave));
    approx_prod_accum #(.ACC_W(24), .CNT_W(2)) dut_c2 (.clk(clk), .rst(rst), .bus(c_if.slave));

`ifdef APPROX_ACC_SAT_EN
    localparam int A_EXP_OVER  = 131071;
    localparam int A_EXP_EXACT = 131071;
`else
    localparam int A_EXP_OVER  = 1;
    localparam int A_EXP_EXACT = 0;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [23:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;

    typedef struct {
        int               n;
        logic [4:0][15:0] beats;
        logic [4:0]       gap;
        logic [23:0]      sum;
        logic [7:0]       cnt;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Scoreboard side: every completed main-DUT handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_if.out_valid && m_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_sum", 32'(m_if.out_sum), 32'(mon_e.sum));
                    chk("out_cnt", 32'(m_if.out_cnt), 32'(mon_e.cnt));
                    chk("out_ovf", 32'(m_if.out_ovf), 32'(mon_e.ovf));
                end
            end else if (!m_if.out_valid) begin
                chk("idle_outputs_zero",
                    32'(m_if.out_sum) | 32'(m_if.out_cnt) | 32'(m_if.out_ovf), 32'd0);
            end
        end
    end

    task automatic wait_ready(input string name);
        int k = 0;
        while (!m_if.in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!m_if.in_ready) chk(name, 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            wait_ready("vec_in_ready_timeout");
            m_if.in_valid = 1'b1;
            m_if.in_prod  = v.beats[i];
            m_if.in_last  = (i == v.n - 1);
            if (i == v.n - 1) exp_q.push_back(res_t'({v.sum, v.cnt, 1'b0}));
            @(posedge clk); #1;
            m_if.in_valid = 1'b0;
            m_if.in_last  = 1'b0;
            if (i == v.n - 1) chk("latency_out_valid", 32'(m_if.out_valid), 32'd1);
            else if (v.gap[i]) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic beat_a(input logic [15:0] p, input logic l);
        a_if.in_valid = 1'b1; a_if.in_prod = p; a_if.in_last = l;
        @(posedge clk); #1;
        a_if.in_valid = 1'b0; a_if.in_last = 1'b0;
    endtask

    task automatic beat_c(input logic [15:0] p, input logic l);
        c_if.in_valid = 1'b1; c_if.in_prod = p; c_if.in_last = l;
        @(posedge clk); #1;
        c_if.in_valid = 1'b0; c_if.in_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0].n = 3; vecs[0].beats = {16'd0, 16'd0, 16'd300, 16'd200, 16'd100};
        vecs[0].gap = 5'b00000; vecs[0].sum = 24'd600; vecs[0].cnt = 8'd3;
        vecs[1].n = 2; vecs[1].beats = {16'd0, 16'd0, 16'd0, 16'd7, 16'd5};
        vecs[1].gap = 5'b00011; vecs[1].sum = 24'd12; vecs[1].cnt = 8'd2;
        vecs[2].n = 3; vecs[2].beats = {16'd0, 16'd0, 16'd4, 16'd0, 16'd0};
        vecs[2].gap = 5'b00010; vecs[2].sum = 24'd4; vecs[2].cnt = 8'd3;
        vecs[3].n = 5; vecs[3].beats = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[3].gap = 5'b00000; vecs[3].sum = 24'd327675; vecs[3].cnt = 8'd5;
        vecs[4].n = 1; vecs[4].beats = {16'd0, 16'd0, 16'd0, 16'd0, 16'd9};
        vecs[4].gap = 5'b00000; vecs[4].sum = 24'd9; vecs[4].cnt = 8'd1;

        m_if.in_valid = 0; m_if.in_prod = 0; m_if.in_last = 0; m_if.out_ready = 1;
        a_if.in_valid = 0; a_if.in_prod = 0; a_if.in_last = 0; a_if.out_ready = 1;
        c_if.in_valid = 0; c_if.in_prod = 0; c_if.in_last = 0; c_if.out_ready = 1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(m_if.in_ready), 32'd0);
        chk("rst_out_valid", 32'(m_if.out_valid), 32'd0);
        chk("rst_out_sum", 32'(m_if.out_sum), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(m_if.in_ready), 32'd1);

        for (int v = 0; v < 4; v++) run_vec(vecs[v]);

        // Single full-scale beat held against back-pressure for five cycles.
        wait_ready("hold_ready_timeout");
        m_if.out_ready = 1'b0;
        m_if.in_valid = 1'b1; m_if.in_prod = 16'hFFFF; m_if.in_last = 1'b1;
        exp_q.push_back(res_t'({24'd65535, 8'd1, 1'b0}));
        @(posedge clk); #1;
        m_if.in_valid = 1'b0; m_if.in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("hold_in_ready", 32'(m_if.in_ready), 32'd0);
            chk("hold_out_valid", 32'(m_if.out_valid), 32'd1);
            chk("hold_out_sum", 32'(m_if.out_sum), 32'd65535);
            chk("hold_out_cnt", 32'(m_if.out_cnt), 32'd1);
            @(posedge clk); #1;
        end
        m_if.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("after_hs_out_valid", 32'(m_if.out_valid), 32'd0);
        chk("after_hs_in_ready", 32'(m_if.in_ready), 32'd1);

        // Back-to-back dot products: exactly one cycle with no accept between them.
        m_if.in_valid = 1'b1; m_if.in_prod = 16'd3; m_if.in_last = 1'b1;
        exp_q.push_back(res_t'({24'd3, 8'd1, 1'b0}));
        @(posedge clk); #1;
        m_if.in_prod = 16'd4;
        chk("bubble_in_ready_hold", 32'(m_if.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("bubble_in_ready_idle", 32'(m_if.in_ready), 32'd1);
        exp_q.push_back(res_t'({24'd4, 8'd1, 1'b0}));
        @(posedge clk); #1;
        m_if.in_valid = 1'b0; m_if.in_last = 1'b0;
        chk("bubble_second_valid", 32'(m_if.out_valid), 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of accumulation discards the partial sum.
        wait_ready("rst_accum_ready_timeout");
        m_if.in_valid = 1'b1; m_if.in_prod = 16'd11;
        @(posedge clk); #1;
        m_if.in_prod = 16'd22;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 32'(m_if.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(m_if.in_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_mid_rst_no_result", 32'(m_if.out_valid), 32'd0);
        run_vec(vecs[4]);
        @(posedge clk); #1;

        // Reset while a result is pending drops it.
        wait_ready("rst_hold_ready_timeout");
        m_if.out_ready = 1'b0;
        m_if.in_valid = 1'b1; m_if.in_prod = 16'd50; m_if.in_last = 1'b1;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0; m_if.in_last = 1'b0;
        chk("pending_out_valid", 32'(m_if.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_hold_out_valid", 32'(m_if.out_valid), 32'd0);
        rst = 1'b0;
        m_if.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_hold_dropped", 32'(m_if.out_valid), 32'd0);

        // 17-bit accumulator overflow, then a clean dot product clears the flag.
        beat_a(16'hFFFF, 1'b0); beat_a(16'hFFFF, 1'b0); beat_a(16'd3, 1'b0); beat_a(16'd0, 1'b1);
        chk("a17_over_valid", 32'(a_if.out_valid), 32'd1);
        chk("a17_over_sum", 32'(a_if.out_sum), 32'(A_EXP_OVER));
        chk("a17_over_cnt", 32'(a_if.out_cnt), 32'd4);
        chk("a17_over_ovf", 32'(a_if.out_ovf), 32'd1);
        @(posedge clk); #1;
        beat_a(16'hFFFF, 1'b0); beat_a(16'hFFFF, 1'b0); beat_a(16'd2, 1'b1);
        chk("a17_exact_sum", 32'(a_if.out_sum), 32'(A_EXP_EXACT));
        chk("a17_exact_ovf", 32'(a_if.out_ovf), 32'd1);
        @(posedge clk); #1;
        beat_a(16'd5, 1'b1);
        chk("a17_clean_sum", 32'(a_if.out_sum), 32'd5);
        chk("a17_clean_ovf", 32'(a_if.out_ovf), 32'd0);
        @(posedge clk); #1;

        // 2-bit beat counter saturates while the sum keeps growing.
        for (int b = 0; b < 5; b++) beat_c(16'd1, b == 4);
        chk("c2_valid", 32'(c_if.out_valid), 32'd1);
        chk("c2_cnt_sat", 32'(c_if.out_cnt), 32'd3);
        chk("c2_sum", 32'(c_if.out_sum), 32'd5);
        @(posedge clk); #1;

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
